clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 8: width of the divisor, the counter and the div_in/div_cur ports.
REQ-002 Parameter DIV_RST, default 3: divisor after reset; legal range 2..2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on posedge, except the half-cycle flop (REQ-015) on negedge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  run request; high starts or continues division, low stops at the next period boundary.
REQ-006 div_load  input  1  one-cycle strobe requesting a new divisor.
REQ-007 div_in  input  WIDTH  requested divisor N, sampled when div_load is high.
REQ-008 clk_out  output  1  divided clock, period N clk cycles.
REQ-009 tick  output  1  one-cycle pulse on the first cycle of every output period.
REQ-010 running  output  1  high while state is RUN.
REQ-011 div_cur  output  WIDTH  divisor currently in effect.
REQ-012 div_ack  output  1  one-cycle pulse when a pending divisor becomes div_cur.
REQ-013 div_err  output  1  one-cycle pulse, cycle after div_load with div_in < 2.

Function
REQ-014 States IDLE and RUN; IDLE->RUN on posedge with en=1; RUN->IDLE on the posedge where cnt would wrap (cnt==div_cur-1) with en=0; en=0 elsewhere in RUN has no effect until that wrap.
REQ-015 cnt counts 0..div_cur-1 in RUN, wrapping to 0; the posedge entering RUN or wrapping loads cnt=0 and drives tick=1 for that cycle.
REQ-016 Even N: clk_out high while cnt < N/2, low otherwise (50% duty, posedge-aligned).
REQ-017 Odd N: high phase defined by REQ-031/REQ-032.
REQ-018 In IDLE: cnt=0, clk_out=0, tick=0, running=0.
REQ-019 Accepted div_load (div_in >= 2) writes a pending register; a later load before application overwrites it (last wins).
REQ-020 Pending divisor applied in RUN on the wrap posedge, in IDLE on the next posedge; div_ack pulses the cycle after application; no truncated or stretched period ever appears on clk_out.
REQ-021 div_load with div_in 0 or 1: pending register unchanged, div_err=1 next cycle, div_ack=0.
REQ-022 div_load coincident with a wrap: the new value is not used for that wrap; it applies at the following wrap.
REQ-023 N = 2^WIDTH-1: cnt reaches all-ones minus one then wraps; no overflow.

Reset
REQ-024 rst=1 at posedge: state IDLE, cnt=0, clk_out=0 after the next negedge at the latest, tick=0, running=0, div_ack=0, div_err=0, div_cur=DIV_RST, pending cleared.
REQ-025 Negedge flop also resets synchronously on rst sampled at negedge.
REQ-026 rst has priority over en, div_load and any in-flight wrap or pending application.
REQ-027 After rst deasserts with en=1, RUN is entered on the first posedge with rst=0.

Configuration
REQ-028 Macro CLK_DIV_ODD_50_EN selects odd-divisor duty handling.
REQ-029 Defined: odd N gives 50% duty using a negedge half-cycle flop.
REQ-030 Undefined: no negedge logic exists; design is posedge-only.
REQ-031 With macro, odd N: p = (cnt < (N-1)/2), n = p registered on negedge, clk_out = p | n; high time N/2 clk periods.
REQ-032 Without macro, odd N: clk_out high while cnt < (N-1)/2, high time (N-1)/2 cycles.
REQ-033 Even-N behaviour is identical with and without the macro.

Verification
REQ-034 rst, then en=1, DIV_RST=3, macro defined -> clk_out period 3 clk, high 1.5 clk; tick every 3rd cycle; running=1.
REQ-035 Same stimulus, macro undefined -> period 3, high 1 clk; no negedge flop in netlist.
REQ-036 Running N=4; div_load div_in=6 mid-period -> current 4-cycle period completes; div_ack the cycle after the wrap; next periods 6 clk, 3 high.
REQ-037 div_load div_in=1, then div_in=5 and div_in=7 on consecutive cycles -> div_err one cycle after the first; only 7 applied; one div_ack.
REQ-038 en dropped at cnt=1 with N=8 -> period finishes at cnt=7; IDLE next; clk_out=0, running=0; en=1 again -> tick and clk_out rise next posedge.
REQ-039 rst asserted at cnt=2 of N=5 -> next posedge cnt=0, IDLE, div_cur=3, clk_out low by the following negedge.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             div_load;
  logic [WIDTH-1:0] div_in;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [WIDTH-1:0] div_cur;
  logic             div_ack;
  logic             div_err;

  modport master (
    output en, div_load, div_in,
    input  clk_out, tick, running, div_cur, div_ack, div_err
  );

  modport slave (
    input  en, div_load, div_in,
    output clk_out, tick, running, div_cur, div_ack, div_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider; new divisors take effect only on period boundaries.
// Optional macro CLK_DIV_ODD_50_EN adds a negedge flop giving 50% duty for odd divisors.
module clk_div_prog #(
  parameter int WIDTH   = 8,
  parameter int DIV_RST = 3
) (
  input logic           clk,
  input logic           rst,
  clk_div_prog_if.slave bus
);
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DIV_RST_V = WIDTH'(DIV_RST);
  localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = WIDTH'(0);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] div_cur_r, div_cur_s;
  logic [WIDTH-1:0] pend_r, pend_s;
  logic             pend_vld_r, pend_vld_s;
  logic             tick_r, tick_s;
  logic             ack_r, ack_s;
  logic             err_r, err_s;
  logic             p_r, p_s;
  logic             wrap_s;
  logic             apply_s;
  logic             load_ok_s;

  // Next-state, divisor reload and registered-output decode
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    div_cur_s  = div_cur_r;
    pend_s     = pend_r;
    pend_vld_s = pend_vld_r;
    tick_s     = 1'b0;
    ack_s      = 1'b0;
    err_s      = 1'b0;
    p_s        = 1'b0;

    wrap_s    = (state_r == RUN) && (cnt_r == (div_cur_r - ONE));
    apply_s   = pend_vld_r && (wrap_s || (state_r == IDLE));
    load_ok_s = bus.div_load && (bus.div_in >= DIV_MIN);
    err_s     = bus.div_load && !load_ok_s;

    // The pending value is consumed before a coincident load overwrites it.
    if (apply_s) begin
      div_cur_s = pend_r;
      ack_s     = 1'b1;
    end else begin
      div_cur_s = div_cur_r;
    end

    if (load_ok_s) begin
      pend_s     = bus.div_in;
      pend_vld_s = 1'b1;
    end else if (apply_s) begin
      pend_vld_s = 1'b0;
    end else begin
      pend_vld_s = pend_vld_r;
    end

    case (state_r)
      IDLE: begin
        cnt_s = ZERO;
        if (bus.en) begin
          state_s = RUN;
          tick_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (wrap_s) begin
          cnt_s = ZERO;
          if (bus.en) begin
            tick_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO;
      end
    endcase

    // floor(N/2) is N/2 for even N and (N-1)/2 for odd N.
    if (state_s == RUN) begin
      p_s = (cnt_s < {1'b0, div_cur_s[WIDTH-1:1]});
    end else begin
      p_s = 1'b0;
    end
  end

  // State, counter, divisor and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= ZERO;
      div_cur_r  <= DIV_RST_V;
      pend_r     <= ZERO;
      pend_vld_r <= 1'b0;
      tick_r     <= 1'b0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      p_r        <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      div_cur_r  <= div_cur_s;
      pend_r     <= pend_s;
      pend_vld_r <= pend_vld_s;
      tick_r     <= tick_s;
      ack_r      <= ack_s;
      err_r      <= err_s;
      p_r        <= p_s;
    end
  end

`ifdef CLK_DIV_ODD_50_EN
  logic n_r;

  // Half-cycle extension of the high phase, active for odd divisors only
  always_ff @(negedge clk) begin
    if (rst) begin
      n_r <= 1'b0;
    end else begin
      n_r <= p_r & div_cur_r[0];
    end
  end

  assign bus.clk_out = p_r | n_r;
`else
  assign bus.clk_out = p_r;
`endif

  assign bus.tick    = tick_r;
  assign bus.running = (state_r == RUN);
  assign bus.div_cur = div_cur_r;
  assign bus.div_ack = ack_r;
  assign bus.div_err = err_r;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed plus randomized bench for clk_div_prog against a cycle-index model.
module tb_clk_div_prog;
  localparam int WIDTH   = 8;
  localparam int DIV_RST = 3;
`ifdef CLK_DIV_ODD_50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  clk_div_prog_if #(.WIDTH(WIDTH)) bus ();

  clk_div_prog #(.WIDTH(WIDTH), .DIV_RST(DIV_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: period start cycle index, divisor, pending request
  int cyc;
  bit m_run;
  int m_start;
  int m_n;
  int m_pend;
  bit m_tick, m_ack, m_err, m_p, prev_po;
  int n_ack, n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit wrap, apply, ld;
    int din;
    logic [31:0] exp_co;
    @(posedge clk);
    cyc++;
    ld  = bus.div_load;
    din = int'(bus.div_in);
    if (rst) begin
      m_run = 1'b0; m_n = DIV_RST; m_pend = 0;
      m_tick = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_p = 1'b0;
    end else begin
      wrap   = m_run && ((cyc - m_start) == m_n);
      apply  = (m_pend != 0) && (wrap || !m_run);
      m_ack  = apply;
      m_err  = ld && (din < 2);
      if (apply) begin
        m_n    = m_pend;
        m_pend = 0;
      end
      if (ld && din >= 2) m_pend = din;
      m_tick = 1'b0;
      if (!m_run) begin
        if (bus.en) begin
          m_run = 1'b1; m_start = cyc; m_tick = 1'b1;
        end
      end else if (wrap) begin
        if (bus.en) begin
          m_start = cyc; m_tick = 1'b1;
        end else begin
          m_run = 1'b0;
        end
      end
      m_p = m_run && ((cyc - m_start) < (m_n / 2));
    end
    #1;
    exp_co = 32'(m_p | (ODD50 & prev_po));
    check("tick",    32'(bus.tick),    32'(m_tick));
    check("running", 32'(bus.running), 32'(m_run));
    check("div_cur", 32'(bus.div_cur), 32'(m_n));
    check("div_ack", 32'(bus.div_ack), 32'(m_ack));
    check("div_err", 32'(bus.div_err), 32'(m_err));
    check("clk_out_pos", 32'(bus.clk_out), exp_co);
    n_ack += int'(bus.div_ack);
    n_err += int'(bus.div_err);
    @(negedge clk);
    #1;
    check("clk_out_neg", 32'(bus.clk_out), 32'(m_p));
    prev_po = m_p && ((m_n % 2) == 1);
  endtask

  task automatic load(input int v);
    bus.div_load = 1'b1;
    bus.div_in   = WIDTH'(v);
    cycle();
    bus.div_load = 1'b0;
  endtask

  task automatic wait_tick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      cycle();
      found = bus.tick;
    end
    check("wait_tick", 32'(found), 32'd1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    m_run = 1'b0; m_start = 0; m_n = DIV_RST; m_pend = 0;
    m_tick = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_p = 1'b0; prev_po = 1'b0;
    n_ack = 0; n_err = 0;
    rst = 1'b1; bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;
    @(posedge clk); cyc++;
    @(negedge clk); #1;

    // Reset state, then default divisor 3
    repeat (2) cycle();
    rst = 1'b0; bus.en = 1'b1;
    n_ack = 0;
    repeat (9) cycle();
    check("n3_running", 32'(bus.running), 32'd1);

    // Reload to 4, then 6 mid-period: 4-cycle period must complete first
    load(4);
    wait_tick();
    check("n4_applied", 32'(bus.div_cur), 32'd4);
    repeat (7) cycle();
    wait_tick();
    cycle();
    n_ack = 0;
    load(6);
    cycle();
    check("n6_no_early_ack", 32'(n_ack), 32'd0);
    cycle();
    check("n6_ack_after_wrap", 32'(bus.div_ack), 32'd1);
    check("n6_applied", 32'(bus.div_cur), 32'd6);
    repeat (12) cycle();

    // Rejected 1, then 5 and 7 back to back: only 7 survives
    wait_tick();
    n_ack = 0; n_err = 0;
    load(1);
    check("err_next_cycle", 32'(bus.div_err), 32'd1);
    load(5);
    load(7);
    repeat (20) cycle();
    check("err_count", 32'(n_err), 32'd1);
    check("ack_count", 32'(n_ack), 32'd1);
    check("last_wins", 32'(bus.div_cur), 32'd7);

    // Stop request mid-period with N=8
    load(8);
    wait_tick();
    check("n8_applied", 32'(bus.div_cur), 32'd8);
    cycle();
    bus.en = 1'b0;
    repeat (6) cycle();
    check("stop_still_running", 32'(bus.running), 32'd1);
    cycle();
    check("stop_idle", 32'(bus.running), 32'd0);
    check("stop_clk_low", 32'(bus.clk_out), 32'd0);
    cycle();
    bus.en = 1'b1;
    cycle();
    check("restart_tick", 32'(bus.tick), 32'd1);
    check("restart_clk", 32'(bus.clk_out), 32'd1);

    // Reset at cnt=2 of N=5, restart on first cycle after reset
    load(5);
    wait_tick();
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    check("rst_div_cur", 32'(bus.div_cur), 32'(DIV_RST));
    check("rst_idle", 32'(bus.running), 32'd0);
    rst = 1'b0;
    cycle();
    check("rst_release_tick", 32'(bus.tick), 32'd1);

    // Largest divisor
    load(255);
    wait_tick();
    check("n255_applied", 32'(bus.div_cur), 32'd255);
    repeat (520) cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      bus.en       = ($urandom_range(0, 7) != 0);
      bus.div_load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) bus.div_in = WIDTH'($urandom_range(0, 255));
      else                            bus.div_in = WIDTH'($urandom_range(0, 11));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
